// File: rtl/switch_control.sv
// Phoenix router switch controller: round-robin header arbitration, XY route computation,
// output reservation and crossbar connection tables, with release on the end of each transfer.
module switch_control #(
  parameter int NPORT      = 5,
  parameter int FLIT_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH/2-1:0] LOCAL_X = '0,
  parameter logic [ADDR_WIDTH/2-1:0] LOCAL_Y = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NPORT-1:0]            h,
  input  logic [NPORT*FLIT_WIDTH-1:0] data,
  input  logic [NPORT-1:0]            sender,
  output logic [NPORT-1:0]            ack_h,
  output logic [NPORT-1:0]            free,
  output logic [NPORT*3-1:0]          mux_in,
  output logic [NPORT*3-1:0]          mux_out,
  output logic [1:0]                  fsm_state
);

  localparam int HW = ADDR_WIDTH / 2;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  // Handshake: h[i] is a level request held by input i until it sees its one-cycle
  // ack_h[i] pulse; sender[i] stays high for the whole packet and its falling edge
  // releases the connection. No other flow control exists on these signals.

  state_t            state, state_nx;
  logic [2:0]        sel, last, tgt;
  logic [2:0]        pick, idx, route;
  logic              pick_ok, grant;
  logic [NPORT-1:0]  connected, sender_q, eligible, release_v;
  logic [ADDR_WIDTH-1:0] addr;
  logic [HW-1:0]     dx, dy;
  logic              unused_payload;

  assign fsm_state = state;
  assign eligible  = h & ~connected;
  assign release_v = connected & sender_q & ~sender;
  assign grant     = (state == S_GRANT) && free[tgt];

  // Head-flit bits above the address do not influence routing.
  assign unused_payload = ^data;

  // Scan downward so the last hit is the one closest after the pointer.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = NPORT; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % NPORT);
      if (eligible[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    addr  = data[int'(sel)*FLIT_WIDTH +: ADDR_WIDTH];
    dx    = addr[ADDR_WIDTH-1:HW];
    dy    = addr[HW-1:0];
    route = LOCAL;
    if (dx > LOCAL_X)      route = EAST;
    else if (dx < LOCAL_X) route = WEST;
    else if (dy > LOCAL_Y) route = NORTH;
    else if (dy < LOCAL_Y) route = SOUTH;
  end

  always_comb begin
    ack_h = '0;
    if (grant) ack_h[sel] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|eligible) state_nx = S_ARB;
      S_ARB:   state_nx = pick_ok ? S_ROUTE : S_IDLE;
      S_ROUTE: state_nx = S_GRANT;
      S_GRANT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= '0;
      last      <= 3'(NPORT - 1);
      tgt       <= '0;
      free      <= '1;
      mux_in    <= '0;
      mux_out   <= '0;
      connected <= '0;
      sender_q  <= '0;
    end else begin
      state    <= state_nx;
      sender_q <= sender;
      if (state == S_ARB && pick_ok) begin
        sel  <= pick;
        last <= pick;
      end
      if (state == S_ROUTE) tgt <= route;
      // Releases and the grant never touch the same output or the same input.
      for (int i = 0; i < NPORT; i++) begin
        if (release_v[i]) begin
          free[mux_out[i*3 +: 3]] <= 1'b1;
          connected[i]            <= 1'b0;
        end
      end
      if (grant) begin
        free[tgt]                <= 1'b0;
        mux_in[int'(tgt)*3 +: 3] <= sel;
        mux_out[int'(sel)*3 +: 3] <= tgt;
        connected[sel]           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Bench for switch_control at router (1,1): directed latency/route/arbitration/reset steps,
// then randomized request rounds checked against a transaction-level round-robin model.
module tb_switch_control;
  localparam int NPORT = 5;
  localparam int FW    = 16;
  localparam int E = 0, W = 1, N = 2, S = 3, L = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ROUTE = 2'd2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NPORT-1:0]  h = '0;
  logic [NPORT*FW-1:0] data = '0;
  logic [NPORT-1:0]  sender = '0;
  logic [NPORT-1:0]  ack_h, free;
  logic [NPORT*3-1:0] mux_in, mux_out;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;

  switch_control #(.NPORT(NPORT), .FLIT_WIDTH(FW), .ADDR_WIDTH(8),
                   .LOCAL_X(4'd1), .LOCAL_Y(4'd1)) dut (
    .clock(clock), .reset(reset), .h(h), .data(data), .sender(sender),
    .ack_h(ack_h), .free(free), .mux_in(mux_in), .mux_out(mux_out),
    .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    h = '0;
    sender = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for any ack pulse; returns acked input (-1 on timeout) and edges waited.
  task automatic wait_ack(input int budget, output int idx, output int n);
    idx = -1;
    n = 0;
    while (ack_h == '0 && n < budget) begin
      tick();
      n++;
    end
    chk("ack_seen", 32'(ack_h != '0), 32'd1);
    if (ack_h != '0) begin
      chk("ack_onehot", 32'($countones(ack_h)), 32'd1);
      for (int i = 0; i < NPORT; i++) if (ack_h[i]) idx = i;
    end
  endtask

  // Header whose XY route from (1,1) is the requested output.
  function automatic logic [FW-1:0] mk_hdr(input int t);
    logic [3:0] x, y;
    case (t)
      E:       begin x = 4'($urandom_range(2, 15)); y = 4'($urandom_range(0, 15)); end
      W:       begin x = 4'd0; y = 4'($urandom_range(0, 15)); end
      N:       begin x = 4'd1; y = 4'($urandom_range(2, 15)); end
      S:       begin x = 4'd1; y = 4'd0; end
      default: begin x = 4'd1; y = 4'd1; end
    endcase
    return {8'($urandom_range(0, 255)), x, y};
  endfunction

  function automatic logic [2:0] mo(input int i);
    logic [NPORT*3-1:0] v;
    v = mux_out;
    return v[i*3 +: 3];
  endfunction

  function automatic logic [2:0] mi(input int o);
    logic [NPORT*3-1:0] v;
    v = mux_in;
    return v[o*3 +: 3];
  endfunction

  // Transaction-level model state for the random phase.
  int owner[NPORT];
  bit conn_m[NPORT];
  int tgt_of[NPORT];
  int last_m;

  function automatic logic [NPORT-1:0] model_free();
    logic [NPORT-1:0] f;
    for (int o = 0; o < NPORT; o++) f[o] = (owner[o] < 0);
    return f;
  endfunction

  initial begin
    int idx, n, exp_i;
    bit any_ack;
    logic [15:0] hdrs[6];
    int rt_exp[6];
    int t4[NPORT];
    int pend[$];
    int fl[$];
    logic [NPORT-1:0] rel;

    // 1: reset values
    reset = 1'b1;
    tick();
    tick();
    chk("rst_free", 32'(free), 32'h1f);
    chk("rst_ack", 32'(ack_h), 32'h0);
    chk("rst_mux_in", 32'(mux_in), 32'h0);
    chk("rst_mux_out", 32'(mux_out), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();

    // 2: single request, latency and one-cycle ack
    data[4*FW +: FW] = 16'h0021;
    h[4] = 1'b1;
    wait_ack(20, idx, n);
    chk("lat_idx", 32'(idx), 32'd4);
    chk("lat_edges", 32'(n), 32'd3);
    chk("lat_ack", 32'(ack_h), 32'h10);
    h[4] = 1'b0;
    tick();
    chk("lat_ack_once", 32'(ack_h), 32'h0);
    chk("lat_free", 32'(free), 32'h1e);
    chk("lat_mux_in0", 32'(mi(0)), 32'd4);
    chk("lat_mux_out4", 32'(mo(4)), 32'd0);

    // 3: route table at (1,1)
    hdrs[0] = 16'h0011; rt_exp[0] = L;
    hdrs[1] = 16'h0012; rt_exp[1] = N;
    hdrs[2] = 16'h0010; rt_exp[2] = S;
    hdrs[3] = 16'h0001; rt_exp[3] = W;
    hdrs[4] = 16'h0021; rt_exp[4] = E;
    hdrs[5] = 16'h0022; rt_exp[5] = E;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      data[0 +: FW] = hdrs[k];
      h[0] = 1'b1;
      wait_ack(20, idx, n);
      chk("route_idx", 32'(idx), 32'd0);
      h[0] = 1'b0;
      tick();
      chk("route_mux_out", 32'(mo(0)), 32'(rt_exp[k]));
      chk("route_free", 32'(free), 32'(5'h1f & ~(5'd1 << rt_exp[k])));
    end

    // 4: all inputs at once, distinct targets, order 0..4
    do_reset();
    t4[0] = L; t4[1] = E; t4[2] = W; t4[3] = N; t4[4] = S;
    for (int i = 0; i < NPORT; i++) data[i*FW +: FW] = mk_hdr(t4[i]);
    h = '1;
    for (int k = 0; k < NPORT; k++) begin
      wait_ack(20, idx, n);
      chk("rr_all_order", 32'(idx), 32'(k));
      if (idx >= 0) h[idx] = 1'b0;
      tick();
      chk("rr_all_mux_out", 32'(mo(k)), 32'(t4[k]));
    end
    chk("rr_all_free", 32'(free), 32'h0);

    // 5: contention for LOCAL, retry until release
    do_reset();
    data[0 +: FW] = 16'h0011;
    data[FW +: FW] = 16'h0011;
    h[1:0] = 2'b11;
    wait_ack(20, idx, n);
    chk("cont_first", 32'(idx), 32'd0);
    h[0] = 1'b0;
    sender[0] = 1'b1;
    any_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      any_ack |= (ack_h != '0);
    end
    chk("cont_blocked", 32'(any_ack), 32'd0);
    chk("cont_free_held", 32'(free), 32'h0f);
    sender[0] = 1'b0;
    tick();
    chk("cont_released", 32'(free), 32'h1f);
    wait_ack(4, idx, n);
    chk("cont_second", 32'(idx), 32'd1);
    h[1] = 1'b0;
    tick();
    chk("cont_mux_in4", 32'(mi(4)), 32'd1);

    // 6: reset in the ROUTE cycle drops the grant
    do_reset();
    data[4*FW +: FW] = 16'h0021;
    h[4] = 1'b1;
    tick();
    tick();
    chk("rr6_in_route", 32'(fsm_state), 32'(ST_ROUTE));
    reset = 1'b1;
    tick();
    chk("rr6_no_ack", 32'(ack_h), 32'h0);
    chk("rr6_free", 32'(free), 32'h1f);
    chk("rr6_idle", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b0;
    wait_ack(20, idx, n);
    chk("rr6_regrant", 32'(idx), 32'd4);
    chk("rr6_lat", 32'(n), 32'd3);
    h[4] = 1'b0;
    tick();

    // Random rounds against the round-robin model
    do_reset();
    last_m = NPORT - 1;
    for (int i = 0; i < NPORT; i++) begin
      owner[i] = -1;
      conn_m[i] = 1'b0;
    end
    for (int r = 0; r < 30; r++) begin
      pend.delete();
      fl.delete();
      for (int o = 0; o < NPORT; o++) if (owner[o] < 0) fl.push_back(o);
      for (int i = 0; i < NPORT; i++) begin
        if (!conn_m[i] && fl.size() > 0 && $urandom_range(0, 1) == 1) begin
          int k;
          k = $urandom_range(0, fl.size() - 1);
          tgt_of[i] = fl[k];
          fl.delete(k);
          data[i*FW +: FW] = mk_hdr(tgt_of[i]);
          h[i] = 1'b1;
          pend.push_back(i);
        end
      end
      while (pend.size() > 0) begin
        wait_ack(20, idx, n);
        exp_i = -1;
        for (int k = 1; k <= NPORT && exp_i < 0; k++) begin
          int c;
          c = (last_m + k) % NPORT;
          foreach (pend[q]) if (pend[q] == c) exp_i = c;
        end
        chk("rand_order", 32'(idx), 32'(exp_i));
        if (idx < 0) begin
          h = '0;
          pend.delete();
          tick();
        end else begin
          last_m = exp_i;
          conn_m[exp_i] = 1'b1;
          owner[tgt_of[exp_i]] = exp_i;
          foreach (pend[q]) if (pend[q] == exp_i) begin
            pend.delete(q);
            break;
          end
          h[exp_i] = 1'b0;
          tick();
          chk("rand_ack_once", 32'(ack_h), 32'h0);
          chk("rand_free", 32'(free), 32'(model_free()));
          chk("rand_mux_out", 32'(mo(exp_i)), 32'(tgt_of[exp_i]));
          chk("rand_mux_in", 32'(mi(tgt_of[exp_i])), 32'(exp_i));
        end
      end
      rel = '0;
      for (int i = 0; i < NPORT; i++) if (conn_m[i] && $urandom_range(0, 2) != 0) rel[i] = 1'b1;
      if (rel != '0) begin
        sender = rel;
        tick();
        sender = '0;
        tick();
        for (int i = 0; i < NPORT; i++) begin
          if (rel[i]) begin
            conn_m[i] = 1'b0;
            owner[tgt_of[i]] = -1;
          end
        end
        chk("rand_release", 32'(free), 32'(model_free()));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
